// File: rtl/mem_access.sv
// mem_access: MEM stage of the five-stage pipeline with the MEM/WB register
// built in. Loads and stores go to data RAM over a req/ack handshake; the
// pipeline is stalled while an access is outstanding.
//
// Ports
//   clk, rst (async, active-low)
//   EX bundle in : ex_valid, flush, mem_*_in, result_in, reg_write_*_in,
//                  current_pc_addr_in, hi/lo_write_data_in, hilo_write_en_in
//   control out  : stall_req, addr_error (1-cycle), bus_error (1-cycle)
//   RAM side     : ram_req, ram_we, ram_addr, ram_byte_en, ram_write_data,
//                  ram_ack, ram_rdata
//   WB bundle out: wb_* (registered copy of the EX bundle plus RAM read data)
module mem_access #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic        flush,
    input  logic        mem_read_flag_in,
    input  logic        mem_write_flag_in,
    input  logic        mem_sign_flag_in,
    input  logic [3:0]  mem_sel_in,
    input  logic [31:0] mem_write_data_in,
    input  logic [31:0] result_in,
    input  logic        reg_write_en_in,
    input  logic [4:0]  reg_write_addr_in,
    input  logic [31:0] current_pc_addr_in,
    input  logic [31:0] hi_write_data_in,
    input  logic [31:0] lo_write_data_in,
    input  logic        hilo_write_en_in,
    output logic        stall_req,
    output logic        addr_error,
    output logic        bus_error,
    output logic        ram_req,
    output logic        ram_we,
    output logic [31:0] ram_addr,
    output logic [3:0]  ram_byte_en,
    output logic [31:0] ram_write_data,
    input  logic        ram_ack,
    input  logic [31:0] ram_rdata,
    output logic [31:0] wb_ram_read_data,
    output logic        wb_mem_read_flag,
    output logic        wb_mem_write_flag,
    output logic        wb_mem_sign_flag,
    output logic [3:0]  wb_mem_sel,
    output logic [31:0] wb_result,
    output logic        wb_reg_write_en,
    output logic [4:0]  wb_reg_write_addr,
    output logic [31:0] wb_current_pc_addr,
    output logic [31:0] wb_hi_write_data,
    output logic [31:0] wb_lo_write_data,
    output logic        wb_hilo_write_en
);

    localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    // Last counter value before the timeout fires (counter counts ack-less BUSY cycles).
    localparam logic [CW-1:0] TO_LAST = (TIMEOUT_CYCLES == 0) ? '0 : CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic {IDLE, BUSY} state_t;
    typedef enum logic [1:0] {WB_BUBBLE, WB_LIVE, WB_LIVE_KILL, WB_LATCHED} wb_act_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] count_reg, count_next;
    logic          flush_pending_reg, flush_pending_next;
    wb_act_t       wb_act;
    logic          start_req, end_req, timeout_hit, stall_c, addr_err_c;

    // Bundle latched at request time; upstream inputs are ignored while BUSY.
    logic        l_read, l_write, l_sign, l_reg_we, l_hilo_we;
    logic [3:0]  l_sel;
    logic [4:0]  l_waddr;
    logic [31:0] l_result, l_pc, l_hi, l_lo;

    logic [1:0]  a;
    logic        mem_op, legal;
    logic [3:0]  byte_en_c;
    logic [31:0] wdata_c;

    assign a      = result_in[1:0];
    assign mem_op = ex_valid & (mem_read_flag_in | mem_write_flag_in);

    always_comb begin
        legal     = 1'b0;
        byte_en_c = 4'b0000;
        case (mem_sel_in)
            4'b0001: begin legal = 1'b1;          byte_en_c = 4'b0001 << a; end
            4'b0011: begin legal = ~a[0];         byte_en_c = 4'b0011 << a; end
            4'b1111: begin legal = (a == 2'b00);  byte_en_c = 4'b1111;      end
            default: begin legal = 1'b0;          byte_en_c = 4'b0000;      end
        endcase
    end

    // Replicate the right-aligned store data onto every lane it may land on.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            always_comb begin
                case (mem_sel_in)
                    4'b0001: wdata_c[gi*8 +: 8] = mem_write_data_in[7:0];
                    4'b0011: wdata_c[gi*8 +: 8] = mem_write_data_in[(gi%2)*8 +: 8];
                    default: wdata_c[gi*8 +: 8] = mem_write_data_in[gi*8 +: 8];
                endcase
            end
        end
    endgenerate

    always_comb begin
        state_next         = state_reg;
        count_next         = count_reg;
        flush_pending_next = flush_pending_reg;
        stall_c            = 1'b0;
        addr_err_c         = 1'b0;
        start_req          = 1'b0;
        end_req            = 1'b0;
        timeout_hit        = 1'b0;
        wb_act             = WB_BUBBLE;
        case (state_reg)
            IDLE: begin
                count_next         = '0;
                flush_pending_next = 1'b0;
                if (flush || !ex_valid) begin
                    wb_act = WB_BUBBLE;
                end else if (mem_op && legal) begin
                    stall_c    = 1'b1;
                    start_req  = 1'b1;
                    state_next = BUSY;
                end else if (mem_op) begin
                    addr_err_c = 1'b1;
                    wb_act     = WB_LIVE_KILL;
                end else begin
                    wb_act = WB_LIVE;
                end
            end
            BUSY: begin
                stall_c = 1'b1;
                if (ram_ack) begin
                    // Ack wins over a timeout landing in the same cycle.
                    stall_c            = 1'b0;
                    end_req            = 1'b1;
                    wb_act             = (flush_pending_reg || flush) ? WB_BUBBLE : WB_LATCHED;
                    flush_pending_next = 1'b0;
                    count_next         = '0;
                    state_next         = IDLE;
                end else begin
                    flush_pending_next = flush_pending_reg | flush;
                    if (TIMEOUT_CYCLES != 0 && count_reg == TO_LAST) begin
                        timeout_hit        = 1'b1;
                        end_req            = 1'b1;
                        flush_pending_next = 1'b0;
                        count_next         = '0;
                        state_next         = IDLE;
                    end else begin
                        count_next = count_reg + 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Combinational outputs forced low while reset is held.
    assign stall_req  = rst & stall_c;
    assign addr_error = rst & addr_err_c;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg         <= IDLE;
            count_reg         <= '0;
            flush_pending_reg <= 1'b0;
        end else begin
            state_reg         <= state_next;
            count_reg         <= count_next;
            flush_pending_reg <= flush_pending_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus_error <= 1'b0;
            ram_req <= 1'b0; ram_we <= 1'b0; ram_addr <= '0; ram_byte_en <= '0; ram_write_data <= '0;
            l_read <= 1'b0; l_write <= 1'b0; l_sign <= 1'b0; l_reg_we <= 1'b0; l_hilo_we <= 1'b0;
            l_sel <= '0; l_waddr <= '0; l_result <= '0; l_pc <= '0; l_hi <= '0; l_lo <= '0;
            wb_ram_read_data <= '0; wb_mem_read_flag <= 1'b0; wb_mem_write_flag <= 1'b0;
            wb_mem_sign_flag <= 1'b0; wb_mem_sel <= '0; wb_result <= '0; wb_reg_write_en <= 1'b0;
            wb_reg_write_addr <= '0; wb_current_pc_addr <= '0; wb_hi_write_data <= '0;
            wb_lo_write_data <= '0; wb_hilo_write_en <= 1'b0;
        end else begin
            bus_error <= timeout_hit;
            if (start_req) begin
                ram_req        <= 1'b1;
                ram_we         <= mem_write_flag_in;
                ram_addr       <= {result_in[31:2], 2'b00};
                ram_byte_en    <= byte_en_c;
                ram_write_data <= wdata_c;
                l_read <= mem_read_flag_in; l_write <= mem_write_flag_in; l_sign <= mem_sign_flag_in;
                l_reg_we <= reg_write_en_in; l_hilo_we <= hilo_write_en_in; l_sel <= mem_sel_in;
                l_waddr <= reg_write_addr_in; l_result <= result_in; l_pc <= current_pc_addr_in;
                l_hi <= hi_write_data_in; l_lo <= lo_write_data_in;
            end else if (end_req) begin
                ram_req <= 1'b0;
                ram_we  <= 1'b0;
            end

            case (wb_act)
                WB_LIVE, WB_LIVE_KILL: begin
                    wb_mem_sign_flag   <= mem_sign_flag_in;
                    wb_mem_sel         <= mem_sel_in;
                    wb_result          <= result_in;
                    wb_reg_write_addr  <= reg_write_addr_in;
                    wb_current_pc_addr <= current_pc_addr_in;
                    wb_hi_write_data   <= hi_write_data_in;
                    wb_lo_write_data   <= lo_write_data_in;
                    // A rejected access retires with no architectural side effects.
                    if (wb_act == WB_LIVE) begin
                        wb_mem_read_flag  <= mem_read_flag_in;
                        wb_mem_write_flag <= mem_write_flag_in;
                        wb_reg_write_en   <= reg_write_en_in;
                        wb_hilo_write_en  <= hilo_write_en_in;
                    end else begin
                        wb_mem_read_flag  <= 1'b0;
                        wb_mem_write_flag <= 1'b0;
                        wb_reg_write_en   <= 1'b0;
                        wb_hilo_write_en  <= 1'b0;
                    end
                end
                WB_LATCHED: begin
                    wb_mem_read_flag   <= l_read;
                    wb_mem_write_flag  <= l_write;
                    wb_mem_sign_flag   <= l_sign;
                    wb_mem_sel         <= l_sel;
                    wb_result          <= l_result;
                    wb_reg_write_en    <= l_reg_we;
                    wb_reg_write_addr  <= l_waddr;
                    wb_current_pc_addr <= l_pc;
                    wb_hi_write_data   <= l_hi;
                    wb_lo_write_data   <= l_lo;
                    wb_hilo_write_en   <= l_hilo_we;
                    if (l_read) wb_ram_read_data <= ram_rdata;
                end
                default: begin
                    wb_mem_read_flag  <= 1'b0;
                    wb_mem_write_flag <= 1'b0;
                    wb_mem_sign_flag  <= 1'b0;
                    wb_reg_write_en   <= 1'b0;
                    wb_hilo_write_en  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access (TIMEOUT_CYCLES=4). Expected WB bundles are
// queued when an instruction is presented and popped once it retires.
module tb_mem_access;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, flush, mem_read_flag_in, mem_write_flag_in, mem_sign_flag_in;
    logic [3:0]  mem_sel_in;
    logic [31:0] mem_write_data_in, result_in, current_pc_addr_in, hi_write_data_in, lo_write_data_in;
    logic        reg_write_en_in, hilo_write_en_in;
    logic [4:0]  reg_write_addr_in;
    logic        stall_req, addr_error, bus_error, ram_req, ram_we, ram_ack;
    logic [31:0] ram_addr, ram_write_data, ram_rdata, wb_ram_read_data, wb_result;
    logic [3:0]  ram_byte_en, wb_mem_sel;
    logic        wb_mem_read_flag, wb_mem_write_flag, wb_mem_sign_flag, wb_reg_write_en, wb_hilo_write_en;
    logic [4:0]  wb_reg_write_addr;
    logic [31:0] wb_current_pc_addr, wb_hi_write_data, wb_lo_write_data;

    always #5 clk = ~clk;

    mem_access #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .flush(flush),
        .mem_read_flag_in(mem_read_flag_in), .mem_write_flag_in(mem_write_flag_in),
        .mem_sign_flag_in(mem_sign_flag_in), .mem_sel_in(mem_sel_in),
        .mem_write_data_in(mem_write_data_in), .result_in(result_in),
        .reg_write_en_in(reg_write_en_in), .reg_write_addr_in(reg_write_addr_in),
        .current_pc_addr_in(current_pc_addr_in), .hi_write_data_in(hi_write_data_in),
        .lo_write_data_in(lo_write_data_in), .hilo_write_en_in(hilo_write_en_in),
        .stall_req(stall_req), .addr_error(addr_error), .bus_error(bus_error),
        .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_byte_en(ram_byte_en),
        .ram_write_data(ram_write_data), .ram_ack(ram_ack), .ram_rdata(ram_rdata),
        .wb_ram_read_data(wb_ram_read_data), .wb_mem_read_flag(wb_mem_read_flag),
        .wb_mem_write_flag(wb_mem_write_flag), .wb_mem_sign_flag(wb_mem_sign_flag),
        .wb_mem_sel(wb_mem_sel), .wb_result(wb_result), .wb_reg_write_en(wb_reg_write_en),
        .wb_reg_write_addr(wb_reg_write_addr), .wb_current_pc_addr(wb_current_pc_addr),
        .wb_hi_write_data(wb_hi_write_data), .wb_lo_write_data(wb_lo_write_data),
        .wb_hilo_write_en(wb_hilo_write_en)
    );

    typedef struct {
        logic [31:0] result, pc, hi, lo, rdata;
        logic        reg_we, hilo_we, rd, wr, sg, chk_rdata;
        logic [4:0]  waddr;
        logic [3:0]  sel;
    } wb_t;

    wb_t sb[$];
    int  n_cmp = 0;
    int  n_err = 0;
    int  n_stall;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ex_valid = 0; flush = 0; mem_read_flag_in = 0; mem_write_flag_in = 0; mem_sign_flag_in = 0;
        mem_sel_in = 4'b0000; mem_write_data_in = 0; result_in = 0; reg_write_en_in = 0;
        reg_write_addr_in = 0; current_pc_addr_in = 0; hi_write_data_in = 0; lo_write_data_in = 0;
        hilo_write_en_in = 0; ram_ack = 0; ram_rdata = 0;
    endtask

    // Drives one EX bundle and returns the bundle that should retire from it.
    task automatic present(input logic rd, input logic wr, input logic sg, input logic [3:0] sel,
                           input logic [31:0] res, input logic [31:0] wdata, input logic rwe,
                           input logic [4:0] waddr, input logic [31:0] pc, output wb_t e);
        ex_valid = 1; mem_read_flag_in = rd; mem_write_flag_in = wr; mem_sign_flag_in = sg;
        mem_sel_in = sel; result_in = res; mem_write_data_in = wdata; reg_write_en_in = rwe;
        reg_write_addr_in = waddr; current_pc_addr_in = pc; hi_write_data_in = pc ^ 32'h0F0F_0000;
        lo_write_data_in = ~pc; hilo_write_en_in = ~(rd | wr);
        e.result = res; e.pc = pc; e.hi = pc ^ 32'h0F0F_0000; e.lo = ~pc; e.rdata = 0;
        e.reg_we = rwe; e.hilo_we = ~(rd | wr); e.rd = rd; e.wr = wr; e.sg = sg;
        e.chk_rdata = 0; e.waddr = waddr; e.sel = sel;
    endtask

    task automatic check_wb(input string tag);
        wb_t e;
        n_cmp++;
        assert (sb.size() != 0) else begin
            n_err++;
            $error("FAIL %s: observed empty scoreboard expected a pending entry", tag);
        end
        if (sb.size() == 0) return;
        n_cmp--;
        e = sb.pop_front();
        $display("wb %s: result=%08h we=%0b addr=%0d rd=%0b wr=%0b sel=%b", tag, wb_result,
                 wb_reg_write_en, wb_reg_write_addr, wb_mem_read_flag, wb_mem_write_flag, wb_mem_sel);
        chk({tag, ".result"}, wb_result, e.result);
        chk({tag, ".pc"}, wb_current_pc_addr, e.pc);
        chk({tag, ".reg_we"}, 32'(wb_reg_write_en), 32'(e.reg_we));
        chk({tag, ".waddr"}, 32'(wb_reg_write_addr), 32'(e.waddr));
        chk({tag, ".rd"}, 32'(wb_mem_read_flag), 32'(e.rd));
        chk({tag, ".wr"}, 32'(wb_mem_write_flag), 32'(e.wr));
        chk({tag, ".sg"}, 32'(wb_mem_sign_flag), 32'(e.sg));
        chk({tag, ".sel"}, 32'(wb_mem_sel), 32'(e.sel));
        chk({tag, ".hilo_we"}, 32'(wb_hilo_write_en), 32'(e.hilo_we));
        chk({tag, ".hi"}, wb_hi_write_data, e.hi);
        chk({tag, ".lo"}, wb_lo_write_data, e.lo);
        if (e.chk_rdata) chk({tag, ".rdata"}, wb_ram_read_data, e.rdata);
    endtask

    initial begin
        wb_t e;
        rst = 0;
        clear_inputs();
        #1;
        // Reset: everything low even with a legal access presented.
        present(1, 0, 0, 4'b1111, 32'h100, 0, 1, 3, 32'h40, e);
        #1;
        chk("rst.stall", 32'(stall_req), 0);
        chk("rst.ram_req", 32'(ram_req), 0);
        chk("rst.wb_result", wb_result, 0);
        chk("rst.wb_we", 32'(wb_reg_write_en), 0);
        clear_inputs();
        #10 rst = 1;
        step();

        // ALU op: one-cycle latency, never stalls.
        present(0, 0, 0, 4'b0000, 32'h1234, 0, 1, 5, 32'h100, e);
        sb.push_back(e);
        #1 chk("alu.stall", 32'(stall_req), 0);
        step();
        clear_inputs();
        check_wb("alu");

        // Signed byte load at 0x1003, ack on the third BUSY cycle.
        n_stall = 0;
        present(1, 0, 1, 4'b0001, 32'h1003, 0, 1, 7, 32'h104, e);
        e.rdata = 32'hDEAD_BE80; e.chk_rdata = 1;
        sb.push_back(e);
        #1 if (stall_req) n_stall++;
        chk("lb.req_before", 32'(ram_req), 0);
        step();
        chk("lb.ram_req", 32'(ram_req), 1);
        chk("lb.ram_addr", ram_addr, 32'h1000);
        chk("lb.byte_en", 32'(ram_byte_en), 32'b1000);
        chk("lb.ram_we", 32'(ram_we), 0);
        chk("lb.wb_bubble", 32'(wb_reg_write_en), 0);
        if (stall_req) n_stall++;
        step();
        if (stall_req) n_stall++;
        chk("lb.addr_held", ram_addr, 32'h1000);
        step();
        ram_ack = 1; ram_rdata = 32'hDEAD_BE80;
        #1 if (stall_req) n_stall++;
        chk("lb.stall_cycles", 32'(n_stall), 3);
        step();
        clear_inputs();
        chk("lb.req_drop", 32'(ram_req), 0);
        check_wb("lb");

        // Half store 0xABCD at 0x2002, ack in first BUSY cycle (2-cycle latency).
        present(0, 1, 0, 4'b0011, 32'h2002, 32'h5555_ABCD, 0, 0, 32'h108, e);
        sb.push_back(e);
        step();
        chk("sh.ram_we", 32'(ram_we), 1);
        chk("sh.byte_en", 32'(ram_byte_en), 32'b1100);
        chk("sh.wdata", ram_write_data, 32'hABCD_ABCD);
        chk("sh.ram_addr", ram_addr, 32'h2000);
        ram_ack = 1;
        #1 chk("sh.stall_ack", 32'(stall_req), 0);
        step();
        clear_inputs();
        check_wb("sh");

        // Misaligned word load: addr_error, no request, retires with no effects.
        present(1, 0, 0, 4'b1111, 32'h2001, 0, 1, 9, 32'h10C, e);
        e.reg_we = 0; e.rd = 0; e.wr = 0;
        sb.push_back(e);
        #1 chk("lw_mis.addr_error", 32'(addr_error), 1);
        chk("lw_mis.stall", 32'(stall_req), 0);
        step();
        clear_inputs();
        chk("lw_mis.ram_req", 32'(ram_req), 0);
        check_wb("lw_mis");

        // Illegal size and odd half address also fault; flush masks a fault.
        present(1, 0, 0, 4'b0111, 32'h3000, 0, 1, 2, 32'h110, e);
        #1 chk("bad_sel.addr_error", 32'(addr_error), 1);
        present(0, 1, 0, 4'b0011, 32'h3001, 0, 0, 0, 32'h114, e);
        #1 chk("lh_odd.addr_error", 32'(addr_error), 1);
        flush = 1;
        #1 chk("flush_idle.addr_error", 32'(addr_error), 0);
        present(1, 0, 0, 4'b1111, 32'h3000, 0, 1, 2, 32'h118, e);
        #1 chk("flush_idle.stall", 32'(stall_req), 0);
        step();
        clear_inputs();
        chk("flush_idle.ram_req", 32'(ram_req), 0);
        chk("flush_idle.wb_we", 32'(wb_reg_write_en), 0);

        // Flush during BUSY: request runs to completion, retires as a bubble.
        present(1, 0, 0, 4'b1111, 32'h4000, 0, 1, 9, 32'h11C, e);
        step();
        flush = 1;
        step();
        flush = 0;
        chk("flush_busy.req_held", 32'(ram_req), 1);
        chk("flush_busy.addr_held", ram_addr, 32'h4000);
        ram_ack = 1; ram_rdata = 32'h1111_2222;
        step();
        clear_inputs();
        chk("flush_busy.wb_we", 32'(wb_reg_write_en), 0);
        chk("flush_busy.wb_rd", 32'(wb_mem_read_flag), 0);
        chk("flush_busy.req_drop", 32'(ram_req), 0);

        // Timeout: four ack-less BUSY cycles.
        present(1, 0, 0, 4'b1111, 32'h5000, 0, 1, 4, 32'h120, e);
        step();
        clear_inputs();
        for (int i = 0; i < 4; i++) begin
            chk("to.bus_error_early", 32'(bus_error), 0);
            chk("to.req_held", 32'(ram_req), 1);
            step();
        end
        chk("to.bus_error", 32'(bus_error), 1);
        chk("to.ram_req", 32'(ram_req), 0);
        chk("to.stall", 32'(stall_req), 0);
        chk("to.wb_we", 32'(wb_reg_write_en), 0);
        step();
        chk("to.bus_error_pulse", 32'(bus_error), 0);

        // Ack in the would-be timeout cycle wins.
        present(1, 0, 0, 4'b1111, 32'h6000, 0, 1, 6, 32'h124, e);
        e.rdata = 32'hCAFE_F00D; e.chk_rdata = 1;
        sb.push_back(e);
        step();
        clear_inputs();
        step(); step(); step();
        ram_ack = 1; ram_rdata = 32'hCAFE_F00D;
        step();
        clear_inputs();
        chk("late_ack.bus_error", 32'(bus_error), 0);
        check_wb("late_ack");

        // Reset mid-BUSY drops the transaction at once.
        present(0, 1, 0, 4'b1111, 32'h7000, 32'h7777_7777, 0, 0, 32'h128, e);
        step();
        clear_inputs();
        chk("rst_busy.req_before", 32'(ram_req), 1);
        #2 rst = 0;
        #1;
        chk("rst_busy.ram_req", 32'(ram_req), 0);
        chk("rst_busy.ram_we", 32'(ram_we), 0);
        chk("rst_busy.stall", 32'(stall_req), 0);
        chk("rst_busy.wb_result", wb_result, 0);
        rst = 1;
        step();
        chk("rst_busy.idle", 32'(ram_req), 0);
        chk("sb.drained", 32'(sb.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- MEM stage of the five-stage pipeline, with the MEM/WB pipeline register built in.
- Takes EX results, performs load/store accesses to data RAM over a req/ack handshake, and stalls the pipeline while an access is outstanding.
- Feeds the WB stage a registered bundle: result/address, register-write controls, HILO, memory flags, byte select and captured RAM read data.

Parameters:
TIMEOUT_CYCLES, 255, maximum BUSY cycles waiting for ram_ack; 0 disables the timeout.

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-low
ex_valid  input  1  EX bundle valid this cycle
flush  input  1  discard the instruction in this stage
mem_read_flag_in  input  1  load
mem_write_flag_in  input  1  store
mem_sign_flag_in  input  1  sign-extend load
mem_sel_in  input  4  size: 0001 byte, 0011 half, 1111 word
mem_write_data_in  input  32  store data, right-aligned
result_in  input  32  ALU result; effective address for memory ops
reg_write_en_in  input  1  GPR write enable
reg_write_addr_in  input  5  GPR destination
current_pc_addr_in  input  32  PC of the instruction
hi_write_data_in  input  32  HI data
lo_write_data_in  input  32  LO data
hilo_write_en_in  input  1  HILO write enable
stall_req  output  1  hold EX and earlier stages
addr_error  output  1  one-cycle pulse: misaligned address or illegal size
bus_error  output  1  one-cycle pulse: ack timeout
ram_req  output  1  RAM request
ram_we  output  1  RAM write
ram_addr  output  32  word-aligned address
ram_byte_en  output  4  byte lane enables
ram_write_data  output  32  lane-replicated store data
ram_ack  input  1  RAM accepts write / returns read data
ram_rdata  input  32  RAM read data, valid with ram_ack
wb_ram_read_data  output  32  captured RAM word
wb_mem_read_flag, wb_mem_write_flag, wb_mem_sign_flag  output  1 each  registered memory flags
wb_mem_sel  output  4  registered size
wb_result  output  32  registered result_in
wb_reg_write_en  output  1  registered write enable
wb_reg_write_addr  output  5  registered destination
wb_current_pc_addr  output  32  registered PC
wb_hi_write_data, wb_lo_write_data  output  32 each  registered HI/LO data
wb_hilo_write_en  output  1  registered HILO enable

Behaviour:
- Reset (rst=0, asynchronous): state IDLE. Every output is 0. Timeout counter and flush_pending cleared.
- mem_op = ex_valid & (mem_read_flag_in | mem_write_flag_in).
- Address legality, using a = result_in[1:0]:
  - Byte: always legal.
  - Half: legal when a[0]=0.
  - Word: legal when a=00.
  - Any other mem_sel_in value is illegal.
- Lane mapping:
  - Byte enable = 0001<<a. Half enable = 0011<<a. Word enable = 1111.
  - ram_write_data: {4{d[7:0]}} for byte, {2{d[15:0]}} for half, d for word.
  - ram_addr = {result_in[31:2],2'b00}.
- Bubble: all wb_* enables and flags are 0. Data fields are don't-care; the implementation holds their previous values.
- State IDLE:
  - Non-memory valid instruction: MEM/WB register loads the bundle at the next edge (1-cycle latency). stall_req=0.
  - ex_valid=0: MEM/WB loads a bubble.
  - Legal mem_op:
    - stall_req=1 combinationally.
    - At the edge, register ram_req=1 and ram_we=write, and latch addr, byte_en, write data and the whole EX bundle.
    - MEM/WB loads a bubble. Next state BUSY.
  - Illegal mem_op:
    - No RAM request. addr_error=1 this cycle.
    - MEM/WB loads the bundle with wb_reg_write_en=0, wb_hilo_write_en=0 and both mem flags 0.
  - flush=1 in IDLE: overrides everything; MEM/WB loads a bubble, no request, no addr_error.
- State BUSY:
  - ram_req and all ram_* outputs held stable until ack. stall_req=1 until the ack cycle.
  - On ram_ack:
    - stall_req=0 that cycle; ram_req cleared at the edge.
    - wb_ram_read_data <= ram_rdata (loads only).
    - MEM/WB loads the latched bundle. Next state IDLE.
  - Minimum load/store latency: 2 cycles from EX presentation to WB valid (ack in the first BUSY cycle).
  - flush in BUSY: set flush_pending. The transaction is never aborted. On ack, MEM/WB loads a bubble instead, and flush_pending clears.
  - Timeout: counter increments each BUSY cycle without ack. When it reaches TIMEOUT_CYCLES (nonzero), the block drops ram_req, pulses bus_error, loads a bubble and returns to IDLE. An ack arriving in that same cycle wins over the timeout.
- While stall_req=1, upstream holds its inputs constant. The block ignores them until back in IDLE.
- Reset asserted mid-BUSY: immediate IDLE, ram_req=0, transaction dropped.

Test Plan:
- ALU op: result_in=0x1234, reg_write_en_in=1, addr 5 -> next cycle wb_result=0x1234, wb_reg_write_en=1, wb_reg_write_addr=5, stall_req never high.
- Signed byte load at 0x1003, ram_ack 3 cycles after ram_req -> ram_addr=0x1000, ram_byte_en=1000, stall_req high 3 cycles, wb_ram_read_data=ram_rdata, wb_mem_sel=0001, wb_result=0x1003, wb_mem_sign_flag=1.
- Half store 0xABCD at 0x2002 -> ram_we=1, ram_byte_en=1100, ram_write_data=0xABCDABCD, wb_mem_write_flag=1 after ack.
- Word load at 0x2001 -> addr_error pulse, ram_req stays 0, wb_reg_write_en=0.
- Flush during BUSY -> request held until ack, then wb_reg_write_en=0 and wb_mem_read_flag=0.
- TIMEOUT_CYCLES=4, ack never arrives -> bus_error after 4 BUSY cycles, ram_req=0, stall_req=0, state IDLE. Separately, rst low mid-BUSY -> all outputs 0 immediately.
